// File: rtl/alu_share_arb.sv
// Round-robin arbiter that shares one external 16-bit ALU between two requesters through an
// issue/result register pipeline, returning tagged results and tracking per-requester N/Z/V flags.
module alu_share_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_opcode,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_opcode,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_err,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic [2:0]  flags0,
  output logic [2:0]  flags1
);

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpXor = 4'b0010;
  localparam logic [3:0] OpSll = 4'b0100;
  localparam logic [3:0] OpSra = 4'b0101;
  localparam logic [3:0] OpRor = 4'b0110;

  logic        iss_valid_q, iss_id_q;
  logic [3:0]  iss_op_q;
  logic [15:0] iss_a_q, iss_b_q;
  logic        res_valid_q, res_id_q, res_zero_q, res_err_q;
  logic [15:0] res_data_q;
  logic        last_q;
  logic [2:0]  flags0_q, flags0_d, flags1_q, flags1_d;

  logic res_adv, iss_adv, iss_free;
  logic grant1, accept;
  logic [2:0] cur_flags, new_flags;

  always_comb begin
    res_adv  = res_valid_q & rsp_ready;
    iss_adv  = iss_valid_q & (~res_valid_q | res_adv);
    iss_free = ~iss_valid_q | iss_adv;
    // On a tie the port that did not win last time is granted.
    grant1   = req1_valid & (~req0_valid | ~last_q);
    accept   = (req0_valid | req1_valid) & iss_free;
    req0_ready = req0_valid & ~grant1 & iss_free;
    req1_ready = grant1 & iss_free;
  end

  always_comb begin
    flags0_d  = flags0_q;
    flags1_d  = flags1_q;
    cur_flags = iss_id_q ? flags1_q : flags0_q;
    new_flags = cur_flags;
    case (iss_op_q)
      OpAdd, OpSub:               new_flags = {alu_out[15], alu_zero, alu_err};
      OpXor, OpSll, OpSra, OpRor: new_flags = {cur_flags[2], alu_zero, cur_flags[0]};
      default:                    new_flags = cur_flags;
    endcase
    if (iss_adv) begin
      if (iss_id_q) flags1_d = new_flags;
      else          flags0_d = new_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      iss_id_q    <= 1'b0;
      iss_op_q    <= 4'h0;
      iss_a_q     <= 16'h0;
      iss_b_q     <= 16'h0;
      last_q      <= 1'b1;
    end else if (accept) begin
      iss_valid_q <= 1'b1;
      iss_id_q    <= grant1;
      iss_op_q    <= grant1 ? req1_opcode : req0_opcode;
      iss_a_q     <= grant1 ? req1_a : req0_a;
      iss_b_q     <= grant1 ? req1_b : req0_b;
      last_q      <= grant1;
    end else if (iss_adv) begin
      iss_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_data_q  <= 16'h0;
      res_zero_q  <= 1'b0;
      res_err_q   <= 1'b0;
      flags0_q    <= 3'b000;
      flags1_q    <= 3'b000;
    end else begin
      flags0_q <= flags0_d;
      flags1_q <= flags1_d;
      if (iss_adv) begin
        res_valid_q <= 1'b1;
        res_id_q    <= iss_id_q;
        res_data_q  <= alu_out;
        res_zero_q  <= alu_zero;
        res_err_q   <= alu_err;
      end else if (res_adv) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign alu_in1   = iss_a_q;
  assign alu_in2   = iss_b_q;
  assign alu_op    = iss_op_q;
  assign rsp_valid = res_valid_q;
  assign rsp_id    = res_id_q;
  assign rsp_data  = res_data_q;
  assign rsp_zero  = res_zero_q;
  assign rsp_err   = res_err_q;
  assign flags0    = flags0_q;
  assign flags1    = flags1_q;

endmodule
